mc1_sweep_checker: RTL and testbench

Self-checking stimulus/response stage wrapped around the MC1 combinational function block, F(A,B,C,D) = ΠM(0,1,2,8,10,12,14).
- Upstream role: drives the four MC1 inputs through all 16 ABCD codes, 0000 to 1111, holding each code for a fixed number of clocks.
- Downstream role: samples the MC1 output F and compares it against a parameterised truth table.
- Reports: per-vector fail map, mismatch count, first failing code, pass/done flags.
- Use: on-chip or FPGA confirmation that the gate-level MC1 implementation matches its maxterm specification.

---
 rtl/mc1_sweep_checker.sv | 186 ++++++++++++++++++
 tb/tb_mc1_sweep_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc1_sweep_checker.sv
// -----------------------------------------------------------------------------
// mc1_sweep_checker
//
// Purpose:
//   Exhaustive stimulus/response checker for the MC1 combinational block.
//   MC1 implements F(A,B,C,D) = PI M(0,1,2,8,10,12,14).
//   The checker does the following:
//     - Steps abcd through all 16 codes, 0000 to 1111.
//     - Holds each code for SETTLE clocks.
//     - Samples f_in on the edge that ends each hold window.
//     - Compares the sample against the EXPECTED truth table.
//     - Accumulates a fail map, a mismatch count and the first failing code.
//
// Parameters:
//   EXPECTED : bit i = expected F at ABCD = i.
//   SETTLE   : clocks each code is held before F is sampled. Must be >= 1.
//
// Ports:
//   clk        : rising-edge clock.
//   rst_n      : asynchronous active-low reset.
//   start      : level input. Launches a sweep when the FSM is in IDLE or DONE.
//   abcd       : code driven to MC1. abcd[3]=A ... abcd[0]=D.
//   f_in       : MC1 output F, combinational from abcd.
//   busy       : sweep in progress.
//   done       : sweep complete. Held until the next start or reset.
//   pass       : done with zero mismatches.
//   err_count  : number of mismatching codes, 0..16.
//   first_fail : lowest mismatching code. Meaningful only when fail_valid=1.
//   fail_valid : at least one mismatch has been recorded.
//   fail_map   : bit i set if code i mismatched.
//   fsm_state  : current FSM state, exposed for debug and checkers.
//
// Handshake:
//   start is a plain level and is sampled on every edge.
//   It is honoured only in IDLE or DONE and is ignored during RUN.
//   If start is held high, a new sweep launches on the edge after DONE is
//   entered, so done is high for exactly one cycle.
// -----------------------------------------------------------------------------
module mc1_sweep_checker #(
    parameter logic [15:0] EXPECTED = 16'hAAF8,
    parameter int          SETTLE   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  abcd,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_fail,
    output logic        fail_valid,
    output logic [15:0] fail_map,
    output logic [1:0]  fsm_state
);

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("mc1_sweep_checker: SETTLE must be >= 1");
        end
    endgenerate

    // The hold counter is at least 1 bit wide, so SETTLE=1 still elaborates.
    // With SETTLE=1 the counter simply stays at 0.
    localparam int          CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q,      state_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [3:0]    abcd_q,       abcd_d;
    logic          busy_q,       busy_d;
    logic          done_q,       done_d;
    logic          pass_q,       pass_d;
    logic [4:0]    err_count_q,  err_count_d;
    logic [3:0]    first_fail_q, first_fail_d;
    logic          fail_valid_q, fail_valid_d;
    logic [15:0]   fail_map_q,   fail_map_d;
    logic          mismatch;

    // The comparison is indexed by the registered code, never by f_in history.
    assign mismatch = (f_in != EXPECTED[abcd_q]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        abcd_d       = abcd_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        fail_valid_d = fail_valid_q;
        fail_map_d   = fail_map_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Launch: clear all results of the previous sweep.
                    state_d      = ST_RUN;
                    cnt_d        = '0;
                    abcd_d       = 4'd0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_count_d  = 5'd0;
                    first_fail_d = 4'd0;
                    fail_valid_d = 1'b0;
                    fail_map_d   = 16'h0000;
                end
            end

            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // This edge ends the hold window: sample and compare.
                    if (mismatch) begin
                        fail_map_d[abcd_q] = 1'b1;
                        err_count_d        = err_count_q + 5'd1;
                        if (!fail_valid_q) begin
                            first_fail_d = abcd_q;
                            fail_valid_d = 1'b1;
                        end
                    end
                    if (abcd_q == 4'd15) begin
                        // Last code: abcd stays at 15.
                        // pass uses the count that includes code 15's result.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == 5'd0);
                    end else begin
                        abcd_d = abcd_q + 4'd1;
                        cnt_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            abcd_q       <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 5'd0;
            first_fail_q <= 4'd0;
            fail_valid_q <= 1'b0;
            fail_map_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            abcd_q       <= abcd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            fail_valid_q <= fail_valid_d;
            fail_map_q   <= fail_map_d;
        end
    end

    assign abcd       = abcd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;
    assign fail_valid = fail_valid_q;
    assign fail_map   = fail_map_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_mc1_sweep_checker.sv
module tb_mc1_sweep_checker;

  localparam int SETTLE = 4;
  localparam int SWEEP  = 16 * SETTLE;

  // Result word layout: {pass, fail_valid, first_fail[3:0], err_count[4:0], fail_map[15:0]}
  localparam int W = 27;

  // F-model modes
  localparam int M_GOOD  = 0;
  localparam int M_STUCK0 = 1;
  localparam int M_STUCK1 = 2;
  localparam int M_INV12  = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  abcd;
  logic        f_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;
  logic        fail_valid;
  logic [15:0] fail_map;
  logic [1:0]  fsm_state;

  int mode;
  int n_cmp;
  int n_bad;
  logic [W-1:0] exp_q[$];

  mc1_sweep_checker #(.EXPECTED(16'hAAF8), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abcd       (abcd),
    .f_in       (f_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .fail_valid (fail_valid),
    .fail_map   (fail_map),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- MC1 reference and fault models ----------------
  // F is 0 exactly on maxterms 0,1,2,8,10,12,14.
  function automatic logic mc1_ref(input int code);
    return !(code inside {0, 1, 2, 8, 10, 12, 14});
  endfunction

  function automatic logic mc1_model(input int m, input int code);
    case (m)
      M_STUCK0: return 1'b0;
      M_STUCK1: return 1'b1;
      M_INV12:  return (code == 12) ? !mc1_ref(code) : mc1_ref(code);
      default:  return mc1_ref(code);
    endcase
  endfunction

  always_comb f_in = mc1_model(mode, int'(abcd));

  function automatic logic [W-1:0] expect_result(input int m);
    logic [15:0] map;
    logic [4:0]  cnt;
    logic [3:0]  first;
    logic        fv;
    map = '0; cnt = '0; first = '0; fv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mc1_model(m, i) != mc1_ref(i)) begin
        map[i] = 1'b1;
        cnt    = cnt + 5'd1;
        if (!fv) begin
          first = 4'(i);
          fv    = 1'b1;
        end
      end
    end
    return {(cnt == 5'd0), fv, first, cnt, map};
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_abcd"}, 32'(abcd), 32'd0);
    check_eq({tag, "_flags"}, 32'({busy, done, pass, fail_valid}), 32'd0);
    check_eq({tag, "_err"}, 32'(err_count), 32'd0);
    check_eq({tag, "_first"}, 32'(first_fail), 32'd0);
    check_eq({tag, "_map"}, 32'(fail_map), 32'd0);
  endtask

  task automatic compare_result(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_qempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_map"}, 32'(fail_map), 32'(e[15:0]));
      check_eq({tag, "_err"}, 32'(err_count), 32'(e[20:16]));
      check_eq({tag, "_fv"}, 32'(fail_valid), 32'(e[25]));
      if (e[25]) check_eq({tag, "_first"}, 32'(first_fail), 32'(e[24:21]));
      check_eq({tag, "_pass"}, 32'(pass), 32'(e[26]));
    end
  endtask

  // Runs one sweep from a start pulse and checks it.
  //   extra_start_at : a value >= 0 pulses start again after that many edges (must be ignored).
  //   check_steps    : check abcd and busy after every edge.
  //   hold_start     : keep start high throughout and check the one-cycle done pulse.
  task automatic run_sweep(input string tag, input int m, input int extra_start_at,
                           input bit check_steps, input bit hold_start);
    mode = m;
    exp_q.push_back(expect_result(m));
    start = 1'b1;
    tick();                       // edge E0
    if (!hold_start) start = 1'b0;
    check_eq({tag, "_launch_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_launch_clr"}, 32'({done, pass, fail_valid, err_count, fail_map}), 32'd0);
    for (int j = 1; j < SWEEP; j++) begin
      if (!hold_start) start = (j == extra_start_at);
      tick();                     // edge E0+j
      if (check_steps) begin
        check_eq($sformatf("%s_abcd_%0d", tag, j), 32'(abcd), 32'(j / SETTLE));
        check_eq($sformatf("%s_busy_%0d", tag, j), 32'(busy), 32'd1);
      end
    end
    start = hold_start;
    check_eq({tag, "_notdone_63"}, 32'(done), 32'd0);
    tick();                       // edge E0+64
    check_eq({tag, "_done_64"}, 32'(done), 32'd1);
    check_eq({tag, "_busy_64"}, 32'(busy), 32'd0);
    check_eq({tag, "_abcd_64"}, 32'(abcd), 32'd15);
    compare_result(tag);
    if (hold_start) begin
      tick();                     // a new sweep is relaunched here
      check_eq({tag, "_relaunch_done"}, 32'(done), 32'd0);
      check_eq({tag, "_relaunch_busy"}, 32'(busy), 32'd1);
      check_eq({tag, "_relaunch_abcd"}, 32'(abcd), 32'd0);
      check_eq({tag, "_relaunch_pass"}, 32'(pass), 32'd0);
      start = 1'b0;
      // The relaunched sweep runs with the same model.
      exp_q.push_back(expect_result(m));
      for (int j = 1; j < SWEEP; j++) tick();
      check_eq({tag, "_r_notdone"}, 32'(done), 32'd0);
      tick();
      check_eq({tag, "_r_done"}, 32'(done), 32'd1);
      compare_result({tag, "_r"});
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    mode  = M_GOOD;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("idle");

    // The truth-table constant is cross-checked against the maxterm model.
    check_eq("exp_table", 32'(expect_result(M_STUCK0) >> 0 & 27'hFFFF), 32'h0000AAF8);

    run_sweep("good",   M_GOOD,   -1, 1'b1, 1'b0);
    run_sweep("stuck0", M_STUCK0, -1, 1'b0, 1'b0);
    check_eq("stuck0_err9", 32'(err_count), 32'd9);
    check_eq("stuck0_first3", 32'(first_fail), 32'd3);
    run_sweep("stuck1", M_STUCK1, -1, 1'b0, 1'b0);
    check_eq("stuck1_map", 32'(fail_map), 32'h5507);
    run_sweep("inv12",  M_INV12,  -1, 1'b0, 1'b0);
    check_eq("inv12_map", 32'(fail_map), 32'h1000);

    // Asynchronous reset mid-sweep while abcd=7. The expected entry is discarded.
    mode = M_STUCK0;
    exp_q.push_back(expect_result(M_STUCK0));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 7 * SETTLE; j++) tick();
    check_eq("pre_rst_abcd", 32'(abcd), 32'd7);
    check_eq("pre_rst_fv", 32'(fail_valid), 32'd1);
    #2;
    rst_n = 1'b0;                 // asserted between clock edges
    #1;
    check_all_zero("async_rst");
    check_eq("async_rst_state", 32'(fsm_state), 32'd0);
    void'(exp_q.pop_front());
    tick();
    rst_n = 1'b1;
    tick();
    run_sweep("post_rst", M_GOOD, -1, 1'b0, 1'b0);

    // An extra start at abcd=5 must be ignored.
    run_sweep("extra_start", M_GOOD, 5 * SETTLE, 1'b1, 1'b0);
    // A start from DONE with stuck-at-0 clears the prior pass.
    run_sweep("restart", M_STUCK0, -1, 1'b0, 1'b0);
    // With start held high, a new sweep relaunches right after DONE.
    run_sweep("held", M_INV12, -1, 1'b0, 1'b1);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety bound: the whole run uses far fewer cycles than this.
  initial begin
    #500000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
